// File: rtl/ntt_coeff_stream_if.sv
// rtl/ntt_coeff_stream_if.sv - coefficient streams, coefficient-memory load port and NTT core handshake
interface ntt_coeff_stream_if #(
  parameter int DW = 24,
  parameter int AW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          load_mem;
  logic [AW-1:0] A_load;
  logic [DW-1:0] D_load;
  logic          WEB_load;
  logic          start_NTT;
  logic          done_NTT;
  logic [DW-1:0] Q0;

  // master: producer/consumer/memory/core environment, slave: the streaming block
  modport master (
    output in_valid, in_data, out_ready, done_NTT, Q0,
    input  in_ready, out_valid, out_data, busy, load_mem, A_load, D_load, WEB_load, start_NTT
  );

  modport slave (
    input  in_valid, in_data, out_ready, done_NTT, Q0,
    output in_ready, out_valid, out_data, busy, load_mem, A_load, D_load, WEB_load, start_NTT
  );
endinterface

// File: rtl/ntt_coeff_stream.sv
// rtl/ntt_coeff_stream.sv - loads reduced coefficients into NTT memory, starts the core, streams results out
module ntt_coeff_stream #(
  parameter int            N_COEFF    = 256,
  parameter int            DW         = 24,
  parameter int            AW         = 16,
  parameter logic [AW-1:0] BASE_ADDR  = 16'h0000,
  parameter int            Q          = 8380417,
  parameter int            RD_LAT     = 1,
  parameter int            FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ntt_coeff_stream_if.slave bus
);
  localparam int              IW    = $clog2(N_COEFF) + 1;
  localparam int              PW    = $clog2(FIFO_DEPTH);
  localparam int              CW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [DW:0]     Q1    = (DW + 1)'(Q);
  localparam logic [DW:0]     Q2    = (DW + 1)'(2 * Q);
  localparam logic [IW-1:0]   LAST  = IW'(N_COEFF - 1);
  localparam logic [IW-1:0]   NUM   = IW'(N_COEFF);
  localparam logic [PW-1:0]   PMAX  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW:0]     DEPTH = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_ocnt;
  logic            r_in_ready;
  logic            r_load_mem;
  logic            r_web;
  logic            r_start;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata;
  logic [RD_LAT:0] r_vld;
  logic [DW-1:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [CW-1:0]   r_cnt;

  logic [DW:0]     w_ext;
  logic [DW-1:0]   w_red;
  logic [CW-1:0]   w_infl;
  logic            w_beat;
  logic            w_issue;
  logic            w_push;
  logic            w_pop;

  // Inputs are below 2^DW < 3Q, so at most two subtractions bring them into [0,Q)
  always_comb begin
    w_ext = {1'b0, bus.in_data};
    w_red = bus.in_data;
    if (w_ext >= Q2)      w_red = DW'(w_ext - Q2);
    else if (w_ext >= Q1) w_red = DW'(w_ext - Q1);
  end

  always_comb begin
    w_infl = '0;
    for (int i = 0; i <= RD_LAT; i++) w_infl = w_infl + CW'(r_vld[i]);
  end

  assign w_beat  = (r_state == S_LOAD) && r_in_ready && bus.in_valid;
  // Credit rule: every read in flight already owns a FIFO slot
  assign w_issue = (r_state == S_UNLOAD) && (r_idx < NUM) &&
                   (({1'b0, r_cnt} + {1'b0, w_infl}) < DEPTH);
  assign w_push  = r_vld[RD_LAT];
  assign w_pop   = (r_cnt != '0) && bus.out_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = (r_cnt != '0);
  assign bus.out_data  = r_fifo[r_rp];
  assign bus.busy      = !((r_state == S_LOAD) && (r_idx == '0));
  assign bus.load_mem  = r_load_mem;
  assign bus.A_load    = r_addr;
  assign bus.D_load    = r_wdata;
  assign bus.WEB_load  = r_web;
  assign bus.start_NTT = r_start;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= bus.Q0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD;
      r_idx      <= '0;
      r_ocnt     <= '0;
      r_in_ready <= 1'b0;
      r_load_mem <= 1'b0;
      r_web      <= 1'b1;
      r_start    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_vld      <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
    end else begin
      r_start <= 1'b0;
      r_vld   <= (r_vld << 1) | (RD_LAT + 1)'(w_issue);
      if (w_push) r_wp <= (r_wp == PMAX) ? '0 : r_wp + 1'b1;
      if (w_pop)  r_rp <= (r_rp == PMAX) ? '0 : r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      case (r_state)
        S_LOAD: begin
          r_in_ready <= 1'b1;
          if (w_beat) begin
            r_load_mem <= 1'b1;
            r_web      <= 1'b0;
            r_addr     <= BASE_ADDR + AW'(r_idx);
            r_wdata    <= w_red;
            if (r_idx == LAST) begin
              r_idx      <= '0;
              r_in_ready <= 1'b0;
              r_state    <= S_START;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_web <= 1'b1;
          end
        end
        S_START: begin
          r_start    <= 1'b1;
          r_load_mem <= 1'b0;
          r_web      <= 1'b1;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.done_NTT) r_state <= S_UNLOAD;
        end
        S_UNLOAD: begin
          r_load_mem <= 1'b1;
          r_web      <= 1'b1;
          if (w_issue) begin
            r_addr <= BASE_ADDR + AW'(r_idx);
            r_idx  <= r_idx + 1'b1;
          end
          if (w_pop) begin
            if (r_ocnt == LAST) begin
              r_ocnt     <= '0;
              r_idx      <= '0;
              r_load_mem <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_ocnt <= r_ocnt + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_coeff_stream.sv
// tb/tb_ntt_coeff_stream.sv - directed/randomized bench with a memory model and a modular-arithmetic reference
module tb_ntt_coeff_stream;
  localparam int N  = 256;
  localparam int Q  = 8380417;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_coeff_stream_if #(.DW(24), .AW(16)) ifc ();
  ntt_coeff_stream dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [23:0] mem     [N];
  logic [23:0] in_vals [N];
  logic [23:0] exp_out [N];
  logic [15:0] wr_addr [$];
  logic [23:0] wr_data [$];
  logic [23:0] out_q   [$];
  int          out_cyc [$];
  int          cyc = 0;
  int          n_start = 0;
  int          nra = 0;
  int          n_pop = 0;
  int          ready_viol = 0;
  bit          unl_active = 0;
  bit          between = 0;
  bit          prev_stall = 0;
  logic [23:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] xform(input logic [23:0] v, input int i, input int k);
    longint t;
    t = (longint'(v) * k + 7 * i) % Q;
    return 24'(t);
  endfunction

  // Coefficient memory: synchronous write, one-cycle registered read
  always @(posedge clk) begin
    if (ifc.load_mem && !ifc.WEB_load) mem[ifc.A_load[7:0]] <= ifc.D_load;
    ifc.Q0 <= mem[ifc.A_load[7:0]];
    cyc++;
  end

  always @(negedge clk) begin
    if (ifc.load_mem && !ifc.WEB_load) begin
      wr_addr.push_back(ifc.A_load);
      wr_data.push_back(ifc.D_load);
    end
    if (ifc.start_NTT) begin
      n_start++;
      between = 1;
    end
    if (between && ifc.in_ready) ready_viol++;
    if (prev_stall) begin
      check("stall_valid", 32'(ifc.out_valid), 1);
      check("stall_data", 32'(ifc.out_data), 32'(prev_data));
    end
    prev_stall = ifc.out_valid && !ifc.out_ready;
    prev_data  = ifc.out_data;
    if (unl_active) begin
      if (ifc.load_mem && ifc.WEB_load && nra < N && ifc.A_load == 16'(nra)) nra++;
      check("outstanding", 32'(nra - n_pop <= FD), 1);
    end
    if (ifc.out_valid && ifc.out_ready) begin
      out_q.push_back(ifc.out_data);
      out_cyc.push_back(cyc);
      n_pop++;
      if (out_q.size() == N) between = 0;
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"}, 32'(ifc.in_ready), 0);
    check({tag, "_out_valid"}, 32'(ifc.out_valid), 0);
    check({tag, "_busy"}, 32'(ifc.busy), 0);
    check({tag, "_load_mem"}, 32'(ifc.load_mem), 0);
    check({tag, "_A_load"}, 32'(ifc.A_load), 0);
    check({tag, "_D_load"}, 32'(ifc.D_load), 0);
    check({tag, "_WEB_load"}, 32'(ifc.WEB_load), 1);
    check({tag, "_start_NTT"}, 32'(ifc.start_NTT), 0);
  endtask

  task automatic load_beats(input int n, input bit toggle, input int done_at);
    bit ok;
    for (int i = 0; i < n; i++) begin
      ifc.in_valid = 1'b1;
      ifc.in_data  = in_vals[i];
      if (i == done_at) ifc.done_NTT = 1'b1;
      ok = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        if (ifc.in_ready) ok = 1;
      end
      @(posedge clk); #1;
      ifc.done_NTT = 1'b0;
      if (!ok) check("load_accept_timeout", 32'(ok), 1);
      if (toggle) begin
        ifc.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_start();
    for (int t = 0; t < 40 && n_start == 0; t++) @(negedge clk);
    check("start_seen", 32'(n_start > 0), 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_write_count"}, 32'(wr_addr.size()), N);
    for (int i = 0; i < N && i < wr_addr.size(); i++) begin
      check({tag, "_waddr"}, 32'(wr_addr[i]), i);
      check({tag, "_wdata"}, 32'(wr_data[i]), int'(in_vals[i]) % Q);
    end
  endtask

  task automatic prep_unload(input int k);
    for (int i = 0; i < N; i++) begin
      mem[i]     = xform(mem[i], i, k);
      exp_out[i] = xform(24'(int'(in_vals[i]) % Q), i, k);
    end
    out_q.delete();
    out_cyc.delete();
    nra = 0;
    n_pop = 0;
    unl_active = 1;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_beat_count"}, 32'(out_q.size()), N);
    for (int i = 0; i < N && i < out_q.size(); i++)
      check({tag, "_out_data"}, 32'(out_q[i]), 32'(exp_out[i]));
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = '0;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_data = '0;
    ifc.out_ready = 1'b0;
    ifc.done_NTT = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst0");
    @(posedge clk); #1 rst_n = 1'b1;

    // done_NTT while idle in LOAD must be ignored
    @(posedge clk); #1 ifc.done_NTT = 1'b1;
    @(posedge clk); #1 ifc.done_NTT = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_in_ready", 32'(ifc.in_ready), 1);
    check("idle_load_mem", 32'(ifc.load_mem), 0);
    check("idle_busy", 32'(ifc.busy), 0);

    // Abort a partial load with an asynchronous reset
    for (int i = 0; i < N; i++) in_vals[i] = 24'($urandom);
    load_beats(10, 0, -1);
    @(negedge clk);
    check("partial_busy", 32'(ifc.busy), 1);
    check("partial_writes", 32'(wr_addr.size()), 10);
    #1 rst_n = 1'b0;
    #1 check_reset("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
    n_start = 0;

    // Full load, in_valid toggling, boundary values first, done_NTT with the final beat
    for (int i = 0; i < N; i++) in_vals[i] = 24'($urandom);
    in_vals[0] = 24'd0;
    in_vals[1] = 24'd8380416;
    in_vals[2] = 24'd8380417;
    in_vals[3] = 24'd16760834;
    in_vals[4] = 24'd16777215;
    load_beats(N, 1, N - 1);
    wait_start();
    check("red_0", 32'(wr_data[0]), 0);
    check("red_q_minus_1", 32'(wr_data[1]), 8380416);
    check("red_q", 32'(wr_data[2]), 0);
    check("red_2q", 32'(wr_data[3]), 0);
    check("red_max", 32'(wr_data[4]), 16381);
    check_writes("load1");
    check("start_pulses", 32'(n_start), 1);
    check("wait_no_read", 32'(ifc.load_mem), 0);
    check("wait_in_ready", 32'(ifc.in_ready), 0);
    check("wait_busy", 32'(ifc.busy), 1);

    // done_NTT in WAIT: first read is decided on the following cycle
    prep_unload(5);
    ifc.out_ready = 1'b1;
    @(posedge clk); #1 ifc.done_NTT = 1'b1;
    @(posedge clk); #1 ifc.done_NTT = 1'b0;
    @(negedge clk);
    check("unload_not_yet", 32'(ifc.load_mem), 0);
    @(negedge clk);
    check("unload_first_load_mem", 32'(ifc.load_mem), 1);
    check("unload_first_web", 32'(ifc.WEB_load), 1);
    check("unload_first_addr", 32'(ifc.A_load), 0);
    for (int t = 0; t < 800 && out_q.size() < N; t++) @(negedge clk);
    check_outputs("unload1");
    if (out_cyc.size() == N) check("unload1_consecutive", 32'(out_cyc[N-1] - out_cyc[0]), N - 1);
    repeat (3) @(negedge clk);
    unl_active = 0;
    check("after1_busy", 32'(ifc.busy), 0);
    check("after1_in_ready", 32'(ifc.in_ready), 1);
    check("after1_load_mem", 32'(ifc.load_mem), 0);
    check("after1_ready_viol", 32'(ready_viol), 0);

    // Second polynomial: continuous input, random 30% out_ready during unload
    wr_addr.delete();
    wr_data.delete();
    n_start = 0;
    ifc.out_ready = 1'b0;
    for (int i = 0; i < N; i++) in_vals[i] = 24'($urandom);
    @(posedge clk); #1;
    load_beats(N, 0, -1);
    wait_start();
    check_writes("load2");
    check("start_pulses2", 32'(n_start), 1);
    prep_unload(3);
    @(posedge clk); #1 ifc.done_NTT = 1'b1;
    @(posedge clk); #1 ifc.done_NTT = 1'b0;
    for (int t = 0; t < 6000 && out_q.size() < N; t++) begin
      @(posedge clk); #1 ifc.out_ready = ($urandom_range(0, 9) < 3);
    end
    ifc.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    unl_active = 0;
    check_outputs("unload2");
    check("after2_out_valid", 32'(ifc.out_valid), 0);
    check("after2_busy", 32'(ifc.busy), 0);
    check("after2_ready_viol", 32'(ready_viol), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
